// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB requester signals for apb_master_bridge.
// The master modport is the bridge's view; slave is the system/peripheral side.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_write;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  logic [ADDRESS_WIDTH-1:0] PADDR;
  logic                     PSEL1;
  logic                     PSEL2;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [DATA_WIDTH-1:0]    PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfer to GPIO (PSEL1) or
// UART (PSEL2), one-cycle response strobe out. Undecoded slaves error without bus activity.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic          uart;
  } cmd_t;

  logic [1:0]    state;
  cmd_t          cmd;
  logic [CW-1:0] wcnt;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [3:0]    slv;
  logic          in_xfer;

  assign slv     = bus.req_addr[AW-1:AW-4];
  assign in_xfer = (state == S_SETUP) || (state == S_ACCESS);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= S_IDLE;
      cmd       <= '0;
      wcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            // APB side registers only change for decodable slaves
            if (slv == 4'h0 || slv == 4'h1) begin
              cmd.addr  <= {4'b0, bus.req_addr[AW-5:0]};
              cmd.write <= bus.req_write;
              cmd.wdata <= bus.req_wdata;
              cmd.uart  <= slv[0];
              state     <= S_SETUP;
            end else begin
              state     <= S_ERR;
            end
          end
        end
        S_SETUP: begin
          wcnt  <= '0;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY is checked first so a late ready beats the timeout
          if (bus.PREADY) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= bus.PSLVERR;
            rsp_rdata <= (!cmd.write && !bus.PSLVERR) ? bus.PRDATA : '0;
          end else if (wcnt == TO_LAST) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_ERR: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.PADDR     = cmd.addr;
  assign bus.PSEL1     = in_xfer & ~cmd.uart;
  assign bus.PSEL2     = in_xfer &  cmd.uart;
  assign bus.PENABLE   = (state == S_ACCESS);
  assign bus.PWRITE    = cmd.write;
  assign bus.PWDATA    = cmd.wdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed + randomized bench for apb_master_bridge; the bench plays the APB slaves
// (register file per address) and predicts each response from transfer rules.
module tb_apb_master_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

  apb_master_bridge #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // One full command from an idle bridge; nwait = ACCESS cycles with PREADY low
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                      input int nwait, input logic slverr);
    logic [3:0]    fld    = addr[AW-1:AW-4];
    bit            dec_ok = (fld <= 4'h1);
    bit            tmo    = (nwait >= TO);
    int            exp_acc = tmo ? TO : nwait + 1;
    logic [DW-1:0] rd_val = mem_rd(addr);
    logic [AW-1:0] exp_pa = {4'b0, addr[AW-5:0]};
    logic [1:0]    exp_sel = (fld == 4'h0) ? 2'b10 : 2'b01;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            acc = 0;

    if (!dec_ok || tmo) begin
      exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_err = slverr; exp_rd = (wr || slverr) ? '0 : rd_val;
    end

    chk("idle_ready", 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_write = wr; bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    if (!dec_ok) begin
      chk("err_ready", 64'(bus.req_ready), 64'(0));
      chk("err_no_apb", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE}), 64'(0));
      tick();
    end else begin
      chk("setup_sel", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE}), 64'({exp_sel, 1'b0}));
      chk("setup_paddr", 64'(bus.PADDR), 64'(exp_pa));
      chk("setup_pwrite", 64'(bus.PWRITE), 64'(wr));
      if (wr) chk("setup_pwdata", 64'(bus.PWDATA), 64'(wd));
      tick();
      while (!bus.rsp_valid && acc <= TO + 2) begin
        chk("access_ctl", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE}),
            64'({exp_sel, 1'b1, wr}));
        chk("access_paddr", 64'(bus.PADDR), 64'(exp_pa));
        bus.PREADY  = (acc >= nwait);
        bus.PRDATA  = (bus.PREADY && !wr) ? rd_val : $urandom;
        bus.PSLVERR = bus.PREADY ? slverr : 1'($urandom);
        tick();
        acc++;
      end
      chk("access_cycles", 64'(acc), 64'(exp_acc));
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = $urandom;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    chk("rsp_bus_idle", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE}), 64'(0));
    if (dec_ok && wr && !tmo && !slverr) mem[addr] = wd;
    tick();
    chk("rsp_one_cycle", 64'(bus.rsp_valid), 64'(0));
    chk("rsp_hold", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({exp_err, exp_rd}));
  endtask

  initial begin
    int acc_t[$];
    int rsp_t[$];
    logic [DW-1:0] b2b_wd [3];
    int k;

    PRESET = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    @(negedge PCLK);
    chk("rst_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'(0));
    chk("rst_apb", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE}), 64'(0));
    chk("rst_paddr", 64'(bus.PADDR), 64'(0));
    chk("rst_pwdata", 64'(bus.PWDATA), 64'(0));
    PRESET = 1'b0;
    tick();

    // GPIO write then readback
    xfer(32'h0000_0000, 1'b1, 32'hFFFF_00FF, 0, 1'b0);
    xfer(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0);
    chk("gpio_dir_readback", 64'(bus.rsp_rdata), 64'(32'hFFFF_00FF));
    // UART read with 3 wait states
    mem[32'h1000_0004] = 32'hA5A5_A5A5;
    xfer(32'h1000_0004, 1'b0, 32'h0, 3, 1'b0);
    chk("uart_read", 64'(bus.rsp_rdata), 64'(32'hA5A5_A5A5));
    // decode error, timeout, ready on the last allowed cycle, slave error
    xfer(32'h2000_0000, 1'b0, 32'h0, 0, 1'b0);
    xfer(32'h0000_0004, 1'b0, 32'h0, TO + 10, 1'b0);
    mem[32'h0000_0008] = 32'h1234_5678;
    xfer(32'h0000_0008, 1'b0, 32'h0, TO - 1, 1'b0);
    xfer(32'h1000_0008, 1'b0, 32'h0, 1, 1'b1);
    xfer(32'hF000_0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);

    // back-to-back GPIO writes with req_valid held
    for (int i = 0; i < 3; i++) b2b_wd[i] = $urandom;
    k = 0;
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = 32'h0000_0010; bus.req_wdata = b2b_wd[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      bit take;
      take = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) rsp_t.push_back(cyc);
      if (take) acc_t.push_back(cyc);
      tick();
      if (take) begin
        k++;
        if (k < 3) begin
          bus.req_addr = 32'h0000_0010 + 32'(4 * k); bus.req_wdata = b2b_wd[k];
        end else bus.req_valid = 1'b0;
      end
    end
    bus.PREADY = 1'b0;
    chk("b2b_accepts", 64'(acc_t.size()), 64'(3));
    chk("b2b_rsps", 64'(rsp_t.size()), 64'(3));
    if (acc_t.size() == 3 && rsp_t.size() == 3) begin
      chk("b2b_cadence1", 64'(acc_t[1] - acc_t[0]), 64'(3));
      chk("b2b_cadence2", 64'(acc_t[2] - acc_t[1]), 64'(3));
      chk("b2b_latency", 64'(rsp_t[0] - acc_t[0]), 64'(3));
      chk("b2b_accept_in_rsp", 64'(acc_t[1]), 64'(rsp_t[0]));
    end
    for (int i = 0; i < 3; i++) mem[32'h0000_0010 + 32'(4 * i)] = b2b_wd[i];
    xfer(32'h0000_0018, 1'b0, 32'h0, 0, 1'b0);

    // reset asserted during ACCESS
    bus.req_valid = 1'b1; bus.req_addr = 32'h1000_0000; bus.req_write = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_access", 64'(bus.PENABLE), 64'(1));
    PRESET = 1'b1;
    #1;
    chk("mid_rst_apb", 64'({bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE}), 64'(0));
    chk("mid_rst_paddr", 64'(bus.PADDR), 64'(0));
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(1));
    @(negedge PCLK);
    PRESET = 1'b0;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_quiet", 64'({bus.rsp_valid, bus.PSEL1, bus.PSEL2, bus.PENABLE}), 64'(0));
      tick();
    end
    bus.PREADY = 1'b0;
    mem.delete();
    xfer(32'h1000_000C, 1'b1, 32'h0BAD_F00D, 2, 1'b0);
    xfer(32'h1000_000C, 1'b0, 32'h0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [3:0]    fld;
      logic [AW-1:0] a;
      int            r, nw;
      r = $urandom_range(0, 7);
      fld = (r < 3) ? 4'h0 : (r < 6) ? 4'h1 : (r == 6) ? 4'(2 + $urandom_range(0, 13)) : 4'hF;
      a = {fld, 28'(4 * $urandom_range(0, 7))};
      r = $urandom_range(0, 9);
      nw = (r < 6) ? $urandom_range(0, 2) : (r < 9) ? $urandom_range(3, 5)
         : (($urandom_range(0, 1) == 0) ? TO - 1 : TO + 2);
      xfer(a, 1'($urandom), $urandom, nw, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
